iomem_gpio: RTL and testbench
=============================

# iomem_gpio

Parametrised GPIO peripheral for the picosoc `iomem` bus; successor to the fixed 16-bit output-only GPIO register. Adds:
- per-pin direction control
- set/clear/toggle write ports
- synchronised inputs with sticky rising-edge interrupts
- a programmable hardware blink timer, so LEDs can blink with no CPU involvement

Instantiated beside `picosoc_noflash` in the board top, on the `sys_clk` domain.

## Interface
- `NGPIO`, 8 — number of pins, 1..32; register bits above NGPIO-1 read 0, writes ignored
- `BASE_HI`, 8'h03 — block selected when `iomem_addr[31:24] == BASE_HI`
- `SYNC_STAGES`, 2 — input synchroniser depth, ≥2
- `BLINK_DIV_RST`, 50_000_000 — reset value of BLINK_DIV

Ports:
- `sys_clk` in 1 — sole clock
- `resetn` in 1 — reset, synchronous, active-low
- `iomem_valid` in 1 — bus request
- `iomem_ready` out 1 — one-cycle acknowledge
- `iomem_wstrb` in 4 — byte write strobes; 0 = read
- `iomem_addr` in 32 — byte address
- `iomem_wdata` in 32 — write data
- `iomem_rdata` out 32 — read data, valid while `iomem_ready`=1, else 0
- `gpio_in` in NGPIO — asynchronous pad inputs
- `gpio_out` out NGPIO — pad output values
- `gpio_oe` out NGPIO — pad output enables, 1 = drive
- `irq` out 1 — level interrupt, `|(IRQ_STAT & IRQ_EN)`

## Operation
Register map, decoded on `iomem_addr[7:2]`. Each entry gives offset, name, access and reset value:
- 0x00 OUT, rw, reset 0
- 0x04 DIR, rw, reset 0
- 0x08 IN, ro — synchronised pins
- 0x0C SET, wo — write-1 sets OUT bits
- 0x10 CLR, wo — write-1 clears OUT bits
- 0x14 TGL, wo — write-1 inverts OUT bits
- 0x18 IRQ_EN, rw, reset 0
- 0x1C IRQ_STAT, rw1c, reset 0
- 0x20 BLINK_EN, rw, reset 0
- 0x24 BLINK_DIV, rw, reset BLINK_DIV_RST

Bus rules:
- Write-only registers read 0.
- Unmapped offsets read 0, ignore writes, and are still acknowledged.
- All writes are byte-masked by `iomem_wstrb`; this includes SET/CLR/TGL/IRQ_STAT masks.
- Unselected addresses: `iomem_ready` stays 0 and nothing changes.

Pin outputs:
- `gpio_out = (OUT & ~BLINK_EN) | ({NGPIO{phase}} & BLINK_EN)`
- `gpio_oe = DIR`

Blink timer:
- 32-bit counter counts 0..BLINK_DIV-1; on the terminal count it wraps to 0 and toggles `phase`.
- BLINK_DIV = 0 freezes both counter and phase.
- Any write to BLINK_DIV clears the counter and `phase` in the same cycle.

Inputs and interrupts:
- Each input passes through a SYNC_STAGES flop chain, then a `prev` flop.
- A rising edge is `sync & ~prev`. It sets the matching IRQ_STAT bit whatever IRQ_EN holds.
- Edges are masked for the first SYNC_STAGES+1 cycles after reset release.
- A W1C write and a new edge on the same bit in the same cycle: set wins.

## Timing
- Access accepted at edge T when `iomem_valid && sel && !iomem_ready`.
- `iomem_ready`=1 for exactly cycle T+1, carrying `iomem_rdata` of the pre-write register value.
- `iomem_ready` drops at T+2; back-to-back accesses therefore cost 2 cycles each.
- Register writes are visible on `gpio_out`/`gpio_oe`/`irq` from T+1.
- A pin change captured at edge k:
  - appears in IN at edge k+SYNC_STAGES;
  - sets IRQ_STAT at edge k+SYNC_STAGES+1;
  - `irq` follows combinationally in that same cycle.
- Blink half-period is exactly BLINK_DIV cycles.
- Reset, including mid-access: all registers go to their reset values, counter and phase clear, `iomem_ready`=0, `iomem_rdata`=0, `gpio_out`=0, `gpio_oe`=0, `irq`=0.
- An access pending when reset asserts is dropped and not acknowledged.

## Structure
- Package `gpio_pkg`: register offset constants (OFS_OUT … OFS_BLINK_DIV) and the `REG_IDX_W`=6 decode width.
- Sub-module `gpio_blink_timer`:
  - ports: `sys_clk`, `resetn`, `div[31:0]`, `restart`, `phase`;
  - holds the counter and phase flop.
- Synchroniser, edge detect and bus decode stay in `iomem_gpio`.

## Test plan
- **Reset values:** after reset, read every offset → OUT=0, DIR=0, IRQ_STAT=0, BLINK_DIV=BLINK_DIV_RST; `gpio_oe`=0, `irq`=0, `iomem_ready` high for one cycle per access.
- **Set/clear/toggle:** write OUT=0xA5, SET=0x0F, CLR=0x80, TGL=0x03 → OUT reads 0x2C. Write 0xFFFF to OUT with wstrb=4'b0010 and NGPIO=8 → OUT unchanged.
- **Edge interrupt:** IRQ_EN=0x01, drive `gpio_in[0]` 0→1 → IRQ_STAT=0x01 after SYNC_STAGES+1 cycles, `irq`=1. W1C of 0x01 in the same cycle as a new edge → bit stays 1. Falling edge → no set.
- **Blink:** BLINK_DIV=4, BLINK_EN=0x02, OUT=0 → `gpio_out[1]` toggles every 4 cycles, `gpio_out[0]`=0. BLINK_DIV=0 → output frozen.
- **Decode:** access with addr 0x0400_0000 → no ready, no state change. Read from offset 0x3C → rdata 0 with ready.
- **Mid-access reset:** assert `resetn`=0 the cycle a write is accepted → no ready, and all registers read back at reset values.

Source files
------------

// File: rtl/iomem_gpio_pkg.sv
// Shared register decode constants for the iomem GPIO block.
// Offsets are word indices taken from iomem_addr[7:2].
package gpio_pkg;
    localparam int REG_IDX_W = 6;

    localparam logic [REG_IDX_W-1:0] OFS_OUT       = 6'h00;
    localparam logic [REG_IDX_W-1:0] OFS_DIR       = 6'h01;
    localparam logic [REG_IDX_W-1:0] OFS_IN        = 6'h02;
    localparam logic [REG_IDX_W-1:0] OFS_SET       = 6'h03;
    localparam logic [REG_IDX_W-1:0] OFS_CLR       = 6'h04;
    localparam logic [REG_IDX_W-1:0] OFS_TGL       = 6'h05;
    localparam logic [REG_IDX_W-1:0] OFS_IRQ_EN    = 6'h06;
    localparam logic [REG_IDX_W-1:0] OFS_IRQ_STAT  = 6'h07;
    localparam logic [REG_IDX_W-1:0] OFS_BLINK_EN  = 6'h08;
    localparam logic [REG_IDX_W-1:0] OFS_BLINK_DIV = 6'h09;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction
endpackage

// File: rtl/iomem_gpio_if.sv
// picosoc iomem bus bundle; the CPU side is master, peripherals are slaves.
interface iomem_gpio_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );
    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_gpio_blink_timer.sv
// Free-running blink divider: phase toggles every `div` cycles, div=0 freezes it.
module gpio_blink_timer (
    input  logic        sys_clk,
    input  logic        resetn,
    input  logic [31:0] div,
    input  logic        restart,
    output logic        phase
);
    logic [31:0] r_cnt;
    logic        r_phase;

    always_ff @(posedge sys_clk) begin
        if (!resetn || restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (div != 32'd0) begin
            // >= keeps the counter bounded even if div shrank below it
            if (r_cnt >= div - 32'd1) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign phase = r_phase;
endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the iomem bus: direction, set/clr/toggle, edge IRQs
// on synchronised inputs, and a hardware blink override per pin.
module iomem_gpio #(
    parameter int          NGPIO         = 8,
    parameter logic [7:0]  BASE_HI       = 8'h03,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [31:0] BLINK_DIV_RST = 32'd50_000_000
) (
    input  logic             sys_clk,
    input  logic             resetn,
    iomem_gpio_if.slave      bus,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_out,
    output logic [NGPIO-1:0] gpio_oe,
    output logic             irq
);
    import gpio_pkg::*;

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [NGPIO-1:0] r_out, r_dir, r_ien, r_stat, r_ben;
    logic [31:0]      r_bdiv;
    logic [SYNC_STAGES-1:0][NGPIO-1:0] r_sync;
    logic [NGPIO-1:0] r_prev;
    logic [ARM_W-1:0] r_arm;
    logic             r_ready;
    logic [31:0]      r_rdata;

    logic                 w_sel, w_acc, w_wr, w_restart, w_phase;
    logic [REG_IDX_W-1:0] w_idx;
    logic [31:0]          w_mask, w_wbits, w_rd;
    logic [NGPIO-1:0]     w_mn, w_wn, w_in, w_rise, w_clr;
    logic                 w_unused_addr;

    assign w_sel     = bus.iomem_addr[31:24] == BASE_HI;
    assign w_acc     = bus.iomem_valid && w_sel && !r_ready;
    assign w_wr      = w_acc && (bus.iomem_wstrb != 4'd0);
    assign w_idx     = bus.iomem_addr[7:2];
    assign w_mask    = strb_mask(bus.iomem_wstrb);
    assign w_wbits   = bus.iomem_wdata & w_mask;
    assign w_mn      = w_mask[NGPIO-1:0];
    assign w_wn      = w_wbits[NGPIO-1:0];
    assign w_restart = w_wr && (w_idx == OFS_BLINK_DIV);
    assign w_unused_addr = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0]};

    assign w_in   = r_sync[SYNC_STAGES-1];
    // Edges are ignored until the flushed-from-reset chain has settled
    assign w_rise = (r_arm == ARM_DONE) ? (w_in & ~r_prev) : '0;
    assign w_clr  = (w_wr && (w_idx == OFS_IRQ_STAT)) ? w_wn : '0;

    always_comb begin
        w_rd = '0;
        case (w_idx)
            OFS_OUT:       w_rd[NGPIO-1:0] = r_out;
            OFS_DIR:       w_rd[NGPIO-1:0] = r_dir;
            OFS_IN:        w_rd[NGPIO-1:0] = w_in;
            OFS_IRQ_EN:    w_rd[NGPIO-1:0] = r_ien;
            OFS_IRQ_STAT:  w_rd[NGPIO-1:0] = r_stat;
            OFS_BLINK_EN:  w_rd[NGPIO-1:0] = r_ben;
            OFS_BLINK_DIV: w_rd = r_bdiv;
            default:       w_rd = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_ien   <= '0;
            r_stat  <= '0;
            r_ben   <= '0;
            r_bdiv  <= BLINK_DIV_RST;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd : 32'd0;
            if (w_wr) begin
                case (w_idx)
                    OFS_OUT:       r_out  <= (r_out & ~w_mn) | w_wn;
                    OFS_DIR:       r_dir  <= (r_dir & ~w_mn) | w_wn;
                    OFS_SET:       r_out  <= r_out | w_wn;
                    OFS_CLR:       r_out  <= r_out & ~w_wn;
                    OFS_TGL:       r_out  <= r_out ^ w_wn;
                    OFS_IRQ_EN:    r_ien  <= (r_ien & ~w_mn) | w_wn;
                    OFS_BLINK_EN:  r_ben  <= (r_ben & ~w_mn) | w_wn;
                    OFS_BLINK_DIV: r_bdiv <= (r_bdiv & ~w_mask) | w_wbits;
                    default: ;
                endcase
            end
            // A fresh edge beats a simultaneous W1C on the same bit
            r_stat <= (r_stat & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_sync <= '0;
            r_prev <= '0;
            r_arm  <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
            r_prev <= w_in;
            if (r_arm != ARM_DONE)
                r_arm <= r_arm + ARM_W'(1);
        end
    end

    gpio_blink_timer u_blink (
        .sys_clk (sys_clk),
        .resetn  (resetn),
        .div     (r_bdiv),
        .restart (w_restart),
        .phase   (w_phase)
    );

    assign gpio_out        = (r_out & ~r_ben) | ({NGPIO{w_phase}} & r_ben);
    assign gpio_oe         = r_dir;
    assign irq             = |(r_stat & r_ien);
    assign bus.iomem_ready = r_ready;
    assign bus.iomem_rdata = r_rdata;
endmodule

// File: tb/tb_iomem_gpio.sv
// Scoreboard bench for iomem_gpio: register-level model, decoupled read monitor.
module tb_iomem_gpio;
    localparam int          NG   = 8;
    localparam int          SS   = 2;
    localparam logic [7:0]  BASE = 8'h03;
    localparam logic [31:0] DIVR = 32'd50_000_000;
    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    iomem_gpio_if bus();
    logic [NG-1:0] pins, gout, goe;
    logic          irq;

    iomem_gpio #(.NGPIO(NG), .BASE_HI(BASE), .SYNC_STAGES(SS), .BLINK_DIV_RST(DIVR)) dut (
        .sys_clk (clk),
        .resetn  (rstn),
        .bus     (bus),
        .gpio_in (pins),
        .gpio_out(gout),
        .gpio_oe (goe),
        .irq     (irq)
    );

    typedef struct { logic [31:0] a; logic [31:0] d; } exp_t;
    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [31:0] m_out, m_dir, m_in, m_ien, m_stat, m_ben, m_bdiv;
    logic        m_phase;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m = 0;
        for (int b = 0; b < 4; b++) if (s[b]) m |= 32'hFF << (8 * b);
        return m;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] ofs);
        case (ofs & 8'hFC)
            8'h00: return m_out;
            8'h04: return m_dir;
            8'h08: return m_in;
            8'h18: return m_ien;
            8'h1C: return m_stat;
            8'h20: return m_ben;
            8'h24: return m_bdiv;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] ofs, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] bm = bmask(s);
        logic [31:0] v  = d & bm;
        logic [31:0] n  = v & MASK;
        case (ofs & 8'hFC)
            8'h00: m_out  = ((m_out & ~bm) | v) & MASK;
            8'h04: m_dir  = ((m_dir & ~bm) | v) & MASK;
            8'h0C: m_out  = m_out | n;
            8'h10: m_out  = m_out & ~n;
            8'h14: m_out  = (m_out ^ n) & MASK;
            8'h18: m_ien  = ((m_ien & ~bm) | v) & MASK;
            8'h1C: m_stat = m_stat & ~n;
            8'h20: m_ben  = ((m_ben & ~bm) | v) & MASK;
            8'h24: m_bdiv = (m_bdiv & ~bm) | v;
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_out = 0; m_dir = 0; m_ien = 0; m_stat = 0; m_ben = 0;
        m_bdiv = DIVR; m_phase = 1'b0;
    endtask

    // Called at a negedge; returns two cycles later at a negedge.
    task automatic acc(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        if (a[31:24] == BASE) begin
            exp_q.push_back('{a, m_read(a[7:0])});
            if (s != 4'd0) m_write(a[7:0], s, d);
        end
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = a;
        bus.iomem_wstrb = s;
        bus.iomem_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] ofs);
        acc({BASE, 16'h0, ofs}, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] d);
        acc({BASE, 16'h0, ofs}, 4'hF, d);
    endtask

    task automatic set_pins(input logic [NG-1:0] v);
        m_stat = m_stat | ({24'd0, v} & ~{24'd0, pins});
        m_in   = {24'd0, v};
        pins   = v;
        repeat (SS + 2) @(negedge clk);
    endtask

    task automatic chk_pins();
        chk("gpio_oe", {24'd0, goe}, m_dir);
        chk("gpio_out", {24'd0, gout}, (m_out & ~m_ben) | (m_phase ? m_ben : 32'd0));
        chk("irq", {31'd0, irq}, {31'd0, |(m_stat & m_ien)});
    endtask

    // Monitor: every acknowledged access is matched against the scoreboard.
    initial begin
        logic prev_rdy;
        exp_t e;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.iomem_ready === 1'b1) begin
                if (prev_rdy) begin
                    total++; bad++;
                    $display("FAIL ready_width ready held >1 cycle t=%0t", $time);
                end
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_ready rdata=%h t=%0t", bus.iomem_rdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rdata@%h", e.a), bus.iomem_rdata, e.d);
                end
            end else begin
                chk("rdata_idle", bus.iomem_rdata, 32'd0);
            end
            prev_rdy = (bus.iomem_ready === 1'b1);
        end
    end

    initial begin
        logic [7:0] otab [11];
        logic [7:0] o;
        logic [3:0] s;
        otab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h3C};
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        bus.iomem_addr  = 32'd0;
        bus.iomem_wdata = 32'd0;
        pins = '0;
        m_in = 0;
        m_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (SS + 3) @(negedge clk);

        // reset state
        chk_pins();
        for (int i = 0; i <= 8'h28; i += 4) rd(8'(i));

        // set / clear / toggle and byte masking
        wr(8'h00, 32'hA5); wr(8'h0C, 32'h0F); wr(8'h10, 32'h80); wr(8'h14, 32'h03);
        rd(8'h00);
        acc({BASE, 24'h00}, 4'b0010, 32'hFFFF);
        rd(8'h00);
        wr(8'h04, 32'h3C);
        chk_pins();

        // edge interrupt, falling edge, W1C
        wr(8'h18, 32'h01);
        set_pins(8'h01);
        chk_pins();
        rd(8'h1C); rd(8'h08);
        set_pins(8'h00);
        rd(8'h1C);
        wr(8'h1C, 32'h01);
        rd(8'h1C);
        chk_pins();

        // W1C accepted on the same edge the new rising edge lands
        pins = 8'h01;
        repeat (SS) @(negedge clk);
        wr(8'h1C, 32'h01);
        m_stat = m_stat | 32'h01;
        m_in = 32'h01;
        repeat (2) @(negedge clk);
        rd(8'h1C);
        chk_pins();

        // randomized traffic (BLINK_DIV read only, so phase stays 0)
        for (int it = 0; it < 60; it++) begin
            o = otab[$urandom_range(0, 10)];
            s = 4'($urandom);
            if (o == 8'h24) s = 4'd0;
            case ($urandom_range(0, 5))
                0: set_pins(NG'($urandom));
                1: acc({8'hA0, 16'h0, o}, 4'hF, $urandom);
                default: acc({BASE, 16'h0, o}, s, $urandom);
            endcase
            chk_pins();
        end
        for (int i = 0; i <= 8'h24; i += 4) rd(8'(i));

        // decode: unselected and unmapped
        acc(32'h0400_0000, 4'hF, 32'hFF);
        rd(8'h00);
        wr(8'h3C, 32'hFFFF_FFFF);
        rd(8'h3C);
        chk_pins();

        // blink: phase toggles every BLINK_DIV cycles after the restart
        wr(8'h00, 32'h00);
        wr(8'h20, 32'h02);
        wr(8'h24, 32'd4);
        for (int n = 1; n <= 20; n++) begin
            m_phase = ((n / 4) % 2) == 1;
            chk($sformatf("blink_n%0d", n), {24'd0, gout}, m_phase ? 32'h02 : 32'h00);
            @(negedge clk);
        end
        wr(8'h24, 32'd0);
        m_phase = 1'b0;
        for (int n = 0; n < 10; n++) begin
            chk("blink_frozen", {24'd0, gout}, 32'h00);
            @(negedge clk);
        end
        rd(8'h24);

        // reset asserted on the accept edge of a write; pins high across release
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {BASE, 24'h00};
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'hFF;
        rstn = 1'b0;
        pins = 8'h80;
        @(posedge clk);
        @(negedge clk);
        chk("reset_no_ready", {31'd0, bus.iomem_ready}, 32'd0);
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'd0;
        repeat (2) @(negedge clk);
        m_reset();
        m_in = 32'h80;
        rstn = 1'b1;
        repeat (SS + 4) @(negedge clk);
        chk_pins();
        for (int i = 0; i <= 8'h24; i += 4) rd(8'(i));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
